sockit_spi_arb: RTL and testbench

SOCKIT_SPI_ARB -- requirements
Module: sockit_spi_arb

---
 rtl/sockit_spi_pkg.sv | 34 +++
 rtl/sockit_spi_cnt.sv | 46 ++++
 rtl/sockit_spi_arb.sv | 104 ++++++++++
 tb/tb_sockit_spi_arb.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/sockit_spi_pkg.sv
// Shared types and helpers for the SPI command arbiter.
package sockit_spi_pkg;

  // Arbiter ownership states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } arb_t;

  // Mux/fork select encoding: XIP on 0, REG/DMA on 1.
  typedef enum logic {
    PORT_XIP = 1'b0,
    PORT_REG = 1'b1
  } port_t;

  // Pick the winner among eligible requesters.
  function automatic port_t arb_pick(input logic  xip_req,
                                     input logic  reg_req,
                                     input logic  pri_xip,
                                     input port_t last);
    port_t win;
    if (xip_req && reg_req) begin
      if (pri_xip) win = PORT_XIP;
      else         win = (last == PORT_XIP) ? PORT_REG : PORT_XIP;
    end else if (xip_req) begin
      win = PORT_XIP;
    end else begin
      win = PORT_REG;
    end
    return win;
  endfunction

endpackage

// File: rtl/sockit_spi_cnt.sv
// Pending-data up/down counter with full flag and sticky underflow error.
module sockit_spi_cnt #(
  parameter int unsigned CNW = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           inc_i,
  input  logic           dec_i,
  output logic [CNW-1:0] cnt_o,
  output logic           full_o,
  output logic           nxt_zero_o,
  output logic           err_o
);

  logic [CNW-1:0] cnt_q, cnt_d;
  logic           err_q, err_d;

  // Next count: +1 on inc, -1 on dec, unchanged on both; a lone dec at 0 flags err.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc_i && !dec_i) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNW'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CNW'(1);
    end
  end

  // Counter and error registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign full_o     = (cnt_q == '1);
  assign nxt_zero_o = (cnt_d == '0);
  assign err_o      = err_q;

endmodule

// File: rtl/sockit_spi_arb.sv
// Arbiter between the XIP and REG/DMA command sources feeding the SPI CDC.
module sockit_spi_arb
  import sockit_spi_pkg::*;
#(
  parameter int unsigned CNW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_xen,
  input  logic           cfg_pri,
  input  logic           xip_vld,
  input  logic           reg_vld,
  input  logic           cmd_rdy,
  input  logic           cmd_end,
  input  logic           cmd_rdf,
  input  logic           cmd_wrf,
  input  logic           sdw_trn,
  input  logic           sdr_trn,
  output logic           sel,
  output logic           cmd_ena,
  output logic           busy,
  output logic [CNW-1:0] pnd_rd,
  output logic [CNW-1:0] pnd_wr,
  output logic           err
);

  arb_t  state_q, state_d;
  port_t sel_q, sel_d;
  port_t last_q, last_d;

  logic cmd_trn;
  logic rd_full, wr_full;
  logic rd_nxt_zero, wr_nxt_zero;
  logic rd_err, wr_err;
  logic stall;

  // A command whose data counter is already full must wait for a drain.
  assign stall   = (cmd_rdf && rd_full) || (cmd_wrf && wr_full);
  assign cmd_ena = (state_q == OWN) && !stall;
  assign cmd_trn = ((sel_q == PORT_REG) ? reg_vld : xip_vld) & cmd_rdy & cmd_ena;

  // Next-state, grant selection and last-owner tracking.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if ((xip_vld && cfg_xen) || reg_vld) begin
          sel_d   = arb_pick(xip_vld && cfg_xen, reg_vld, cfg_pri, last_q);
          last_d  = sel_d;
          state_d = OWN;
        end
      end
      OWN: begin
        if (cmd_trn && cmd_end) state_d = DRAIN;
      end
      DRAIN: begin
        if (rd_nxt_zero && wr_nxt_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, select and last-owner registers; last-owner resets to REG so XIP wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= PORT_XIP;
      last_q  <= PORT_REG;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  sockit_spi_cnt #(.CNW(CNW)) u_cnt_rd (
    .clk_i      (clk),
    .rst_ni     (rst),
    .inc_i      (cmd_trn & cmd_rdf),
    .dec_i      (sdr_trn),
    .cnt_o      (pnd_rd),
    .full_o     (rd_full),
    .nxt_zero_o (rd_nxt_zero),
    .err_o      (rd_err)
  );

  sockit_spi_cnt #(.CNW(CNW)) u_cnt_wr (
    .clk_i      (clk),
    .rst_ni     (rst),
    .inc_i      (cmd_trn & cmd_wrf),
    .dec_i      (sdw_trn),
    .cnt_o      (pnd_wr),
    .full_o     (wr_full),
    .nxt_zero_o (wr_nxt_zero),
    .err_o      (wr_err)
  );

  assign sel  = sel_q;
  assign busy = (state_q != IDLE);
  assign err  = rd_err | wr_err;

endmodule

// File: tb/tb_sockit_spi_arb.sv
// Scoreboard bench for sockit_spi_arb (CNW=2): driver queues expectations, monitor checks on negedge.
module tb_sockit_spi_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_xen = 1'b1, cfg_pri = 1'b0;
  logic       xip_vld = 1'b0, reg_vld = 1'b0, cmd_rdy = 1'b0, cmd_end = 1'b0;
  logic       cmd_rdf = 1'b0, cmd_wrf = 1'b0, sdw_trn = 1'b0, sdr_trn = 1'b0;
  logic       sel, cmd_ena, busy, err;
  logic [1:0] pnd_rd, pnd_wr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic       sel;
    logic       ena;
    logic       busy;
    logic [1:0] prd;
    logic [1:0] pwr;
    logic       err;
  } exp_t;

  exp_t q[$];

  sockit_spi_arb #(.CNW(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_xen (cfg_xen),
    .cfg_pri (cfg_pri),
    .xip_vld (xip_vld),
    .reg_vld (reg_vld),
    .cmd_rdy (cmd_rdy),
    .cmd_end (cmd_end),
    .cmd_rdf (cmd_rdf),
    .cmd_wrf (cmd_wrf),
    .sdw_trn (sdw_trn),
    .sdr_trn (sdr_trn),
    .sel     (sel),
    .cmd_ena (cmd_ena),
    .busy    (busy),
    .pnd_rd  (pnd_rd),
    .pnd_wr  (pnd_wr),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Monitor: compare the queued expectation against DUT outputs mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({sel, cmd_ena, busy, pnd_rd, pnd_wr, err} !==
          {e.sel, e.ena, e.busy, e.prd, e.pwr, e.err}) begin
        failures++;
        $display("FAIL %s: got sel=%b ena=%b busy=%b prd=%0d pwr=%0d err=%b, expected sel=%b ena=%b busy=%b prd=%0d pwr=%0d err=%b",
                 e.name, sel, cmd_ena, busy, pnd_rd, pnd_wr, err,
                 e.sel, e.ena, e.busy, e.prd, e.pwr, e.err);
      end
    end
  end

  task automatic drv(input logic xv, rv, rdy, en, rdf, wrf, sdw, sdr);
    xip_vld = xv; reg_vld = rv; cmd_rdy = rdy; cmd_end = en;
    cmd_rdf = rdf; cmd_wrf = wrf; sdw_trn = sdw; sdr_trn = sdr;
  endtask

  task automatic expect_out(input string n, input logic s, en, b,
                            input logic [1:0] pr, pw, input logic er);
    exp_t e;
    e.name = n; e.sel = s; e.ena = en; e.busy = b;
    e.prd = pr; e.pwr = pw; e.err = er;
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    // Reset held
    drv(0,0,0,0,0,0,0,0);
    expect_out("reset_state", 0,0,0, 0,0, 0); tick;
    rst = 1'b1;

    // Round-robin: both request, XIP wins first, REG next
    drv(1,1,0,0,0,0,0,0); expect_out("rr_idle0",   0,0,0, 0,0,0); tick;
    drv(1,1,1,1,0,0,0,0); expect_out("rr_own_xip", 0,1,1, 0,0,0); tick;
    drv(0,1,0,0,0,0,0,0); expect_out("rr_drain0",  0,0,1, 0,0,0); tick;
    drv(1,1,0,0,0,0,0,0); expect_out("rr_idle1",   0,0,0, 0,0,0); tick;
    drv(0,1,1,1,0,0,0,0); expect_out("rr_own_reg", 1,1,1, 0,0,0); tick;
    drv(0,0,0,0,0,0,0,0); expect_out("rr_drain1",  1,0,1, 0,0,0); tick;
    drv(0,0,0,0,0,0,0,0); expect_out("rr_idle2",   1,0,0, 0,0,0); tick;

    // Fixed priority: XIP owns three transactions in a row
    cfg_pri = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(1,1,0,0,0,0,0,0); expect_out("pri_idle",  (i == 0) ? 1'b1 : 1'b0, 0,0, 0,0,0); tick;
      drv(1,1,1,1,0,0,0,0); expect_out("pri_own",   0,1,1, 0,0,0); tick;
      drv(1,1,0,0,0,0,0,0); expect_out("pri_drain", 0,0,1, 0,0,0); tick;
    end
    drv(0,0,0,0,0,0,0,0); expect_out("pri_idle_end", 0,0,0, 0,0,0); tick;

    // Read counter saturation at 3, then drain/accept, then reset in DRAIN
    drv(1,0,0,0,0,0,0,0); expect_out("sat_idle", 0,0,0, 0,0,0); tick;
    cfg_xen = 1'b0;  // dropping XIP enable must not preempt the owner
    drv(1,0,1,0,1,0,0,0); expect_out("sat_rd1",   0,1,1, 0,0,0); tick;
    drv(1,0,1,0,1,0,0,0); expect_out("sat_rd2",   0,1,1, 1,0,0); tick;
    drv(1,0,1,0,1,0,0,0); expect_out("sat_rd3",   0,1,1, 2,0,0); tick;
    drv(1,0,1,0,1,0,0,0); expect_out("sat_stall", 0,0,1, 3,0,0); tick;
    drv(1,0,1,0,1,0,0,1); expect_out("sat_dec",   0,0,1, 3,0,0); tick;
    drv(1,0,1,1,1,0,0,0); expect_out("sat_acc4",  0,1,1, 2,0,0); tick;
    drv(0,0,0,0,0,0,0,1); expect_out("drn_rd3",   0,0,1, 3,0,0); tick;
    drv(0,0,0,0,0,0,0,0); expect_out("drn_rd2",   0,0,1, 2,0,0); tick;
    rst = 1'b0; #1;
    expect_out("rst_in_drain", 0,0,0, 0,0,0); tick;
    cfg_xen = 1'b1; cfg_pri = 1'b0;
    expect_out("rst_hold",     0,0,0, 0,0,0); tick;
    rst = 1'b1;

    // After reset XIP wins first; drain exit and regrant in back-to-back cycles
    drv(1,1,0,0,0,0,0,0); expect_out("post_rst_idle", 0,0,0, 0,0,0); tick;
    drv(1,0,1,1,0,1,0,0); expect_out("wr_end",        0,1,1, 0,0,0); tick;
    drv(1,0,0,0,0,0,1,0); expect_out("wr_drain",      0,0,1, 0,1,0); tick;
    drv(1,0,0,0,0,0,0,0); expect_out("regrant_idle",  0,0,0, 0,0,0); tick;
    drv(1,0,0,0,0,0,0,0); expect_out("regrant_own",   0,1,1, 0,0,0); tick;
    drv(1,0,1,1,0,0,0,0); expect_out("own_end",       0,1,1, 0,0,0); tick;

    // Underflow sets a sticky error, counter stays at 0
    drv(0,0,0,0,0,0,0,1); expect_out("uflow_drain",   0,0,1, 0,0,0); tick;
    drv(0,0,0,0,0,0,0,0); expect_out("uflow_err",     0,0,0, 0,0,1); tick;
    drv(0,0,0,0,0,0,0,0); expect_out("err_sticky",    0,0,0, 0,0,1); tick;

    // XIP disabled: no grant to XIP, REG still served
    cfg_xen = 1'b0;
    drv(1,0,0,0,0,0,0,0); expect_out("xen_off0",  0,0,0, 0,0,1); tick;
    drv(1,0,0,0,0,0,0,0); expect_out("xen_off1",  0,0,0, 0,0,1); tick;
    drv(1,1,0,0,0,0,0,0); expect_out("xen_reg",   0,0,0, 0,0,1); tick;
    drv(1,1,0,0,0,0,0,0); expect_out("xen_own",   1,1,1, 0,0,1); tick;
    drv(0,0,0,0,0,0,0,0);

    // Bounded wait for the monitor to consume everything
    for (int i = 0; i < 10 && q.size() > 0; i++) tick;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
